// File: rtl/tc21073_mbyte_add_seq.sv
// Byte-serial wide adder front end: walks an external 8-bit full adder LSB byte first.
// Build option: define TC_SUB_EN to add the in_sub port (A - B via ~B and carry-in 1).
module tc21073_mbyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
`ifdef TC_SUB_EN
    input  logic                in_sub,
`endif
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IDXW-1:0] idx_reg;
    logic            carry_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            sub_sel;
    logic            run_active;
    logic            done_active;

    logic [7:0] a_bytes [NBYTES];
    logic [7:0] b_bytes [NBYTES];

`ifdef TC_SUB_EN
    assign sub_sel = in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Byte views of the registered operands, selected by idx during RUN.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
        assign a_bytes[gi] = a_reg[8*gi +: 8];
        assign b_bytes[gi] = b_reg[8*gi +: 8];
    end

    // b_reg holds the effective B (already inverted for subtraction) so both the
    // adder feed and the overflow check use it directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b ^ {W{sub_sel}};
                        carry_reg <= sub_sel | in_cin;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    res_reg[8*idx_reg +: 8] <= add_sum;
                    carry_reg               <= add_cout;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign run_active  = (state_reg == RUN);
    assign done_active = (state_reg == DONE);

    assign in_ready = (state_reg == IDLE) & rst_n;

    assign add_a   = run_active ? a_bytes[idx_reg] : 8'h00;
    assign add_b   = run_active ? b_bytes[idx_reg] : 8'h00;
    assign add_cin = run_active & carry_reg;

    // Result outputs read as zero outside DONE so a discarded partial sum never leaks.
    assign out_valid = done_active;
    assign out_sum   = done_active ? res_reg : '0;
    assign out_cout  = done_active & carry_reg;
    assign out_ovf   = done_active & (a_reg[W-1] == b_reg[W-1]) & (res_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_tc21073_mbyte_add_seq.sv
// Randomized and directed bench for tc21073_mbyte_add_seq with an ideal 8-bit adder
// and a whole-word arithmetic reference model.
module tb_tc21073_mbyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Ideal external 8-bit full adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    tc21073_mbyte_add_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef TC_SUB_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, walk the bytes, check the result, hold DONE for
    // 'hold' cycles (optionally pulsing junk on in_valid), then release.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int hold, input bit junk);
        logic [W-1:0] beff;
        logic         c0;
        logic [W:0]   full;
        longint       s;
        logic         ovf;
        logic [63:0]  m;
        logic [63:0]  pa;
        logic [63:0]  pb;
        beff = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c0};
        if (sub) s = longint'($signed(a)) - longint'($signed(b));
        else     s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        ovf = (s != longint'($signed(full[W-1:0])));

        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
        for (int k = 0; k < NB; k++) begin
            m  = (64'd1 << (8 * k)) - 64'd1;
            pa = {32'd0, a} & m;
            pb = {32'd0, beff} & m;
            chk("run_add_a", {56'd0, add_a}, {56'd0, a[8*k +: 8]});
            chk("run_add_b", {56'd0, add_b}, {56'd0, beff[8*k +: 8]});
            chk("run_add_cin", {63'd0, add_cin}, ((pa + pb + {63'd0, c0}) >> (8 * k)) & 64'd1);
            chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
            chk("valid_early", {63'd0, out_valid}, 64'd0);
            tick();
        end
        chk("valid_latency", {63'd0, out_valid}, 64'd1);
        chk("out_sum", {32'd0, out_sum}, {32'd0, full[W-1:0]});
        chk("out_cout", {63'd0, out_cout}, {63'd0, full[W]});
        chk("out_ovf", {63'd0, out_ovf}, {63'd0, ovf});
        for (int h = 0; h < hold; h++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
            end
            chk("in_ready_done", {63'd0, in_ready}, 64'd0);
            tick();
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_sum", {32'd0, out_sum}, {32'd0, full[W-1:0]});
            chk("hold_cout", {63'd0, out_cout}, {63'd0, full[W]});
            chk("hold_ovf", {63'd0, out_ovf}, {63'd0, ovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", {63'd0, out_valid}, 64'd0);
        chk("release_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_add_a", {56'd0, add_a}, 64'd0);
        $display("op a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h cout=%0d ovf=%0d",
                 a, b, cin, sub, full[W-1:0], full[W], ovf);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_add_bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic corners
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
        // Backpressure with junk offered on the input
        do_op(32'h0BADF00D, 32'h12345678, 1'b1, 1'b0, 5, 1'b1);

        // Reset in the middle of RUN
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'hCAFEF00D;
        in_cin   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_add_bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_idle_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < NB + 2; i++) begin
            tick();
            chk("abort_no_result", {63'd0, out_valid}, 64'd0);
        end
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1, 1'b0);

`ifdef TC_SUB_EN
        do_op(32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0);
        do_op(32'd7, 32'd5, 1'b1, 1'b1, 0, 1'b0);
        do_op(32'h80000000, 32'd1, 1'b0, 1'b1, 0, 1'b0);
`endif

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic sub_r;
`ifdef TC_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            do_op($urandom, $urandom, 1'($urandom), sub_r, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
